// File: rtl/top_line_owner_arb.sv
// top_line_owner_arb
//   Round-robin owner arbiter for one shared pad line driven by four macros.
//   A guard period with drivers disabled separates every hand-over.
//   The mux select changes only while every driver is off.
//
// Parameters
//   GUARD_CYC : dead cycles (oe_gate low) before and after each ownership
//   MAX_HOLD  : OWN cycles before a contended owner is preempted
//
// Ports
//   clk           : clock; all state updates on the rising edge
//   rst_n         : asynchronous active-low reset
//   enable        : arbitration enable; low drains the owner and blocks grants
//   req[3:0]      : level request per macro
//   configuration : pad-line mux select (0..3, bits [3:2] always 0)
//   grant[3:0]    : one-hot grant to the current owner, zero when none
//   oe_gate       : high only while pad-line drivers may be enabled
//   busy          : high whenever the arbiter is not IDLE
module top_line_owner_arb #(
   parameter int GUARD_CYC = 2,
   parameter int MAX_HOLD  = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [3:0] req,
   output logic [3:0] configuration,
   output logic [3:0] grant,
   output logic       oe_gate,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, GUARD, OWN, DRAIN} state_t;

   localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYC - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(MAX_HOLD - 1);

   state_t     state;
   logic [1:0] sel;
   logic [1:0] last_owner;
   logic [3:0] guard_cnt;
   logic [7:0] hold_cnt;
   logic [3:0] grant_r;
   logic       oe_r;
   logic       busy_r;

   logic [1:0] winner;
   logic [1:0] idx;
   logic [3:0] sel_onehot;
   logic       owner_req;
   logic       other_req;
   logic       preempt;

   // Round-robin pick: walk offsets 4..1 so the smallest offset from
   // last_owner (highest priority) is written last and wins.  Offset 4
   // wraps to last_owner itself, the lowest priority.
   always_comb begin
      winner = last_owner;
      idx    = last_owner;
      for (int i = 4; i >= 1; i--) begin
         idx = last_owner + 2'(i);
         if (req[idx]) begin
            winner = idx;
         end
      end
   end

   assign sel_onehot = 4'b0001 << sel;
   assign owner_req  = req[sel];
   assign other_req  = |(req & ~sel_onehot);
   assign preempt    = (hold_cnt == HOLD_LAST) && other_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sel        <= 2'd0;
         last_owner <= 2'd3;
         guard_cnt  <= 4'd0;
         hold_cnt   <= 8'd0;
         grant_r    <= 4'd0;
         oe_r       <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (enable && (req != 4'd0)) begin
                  sel        <= winner;
                  last_owner <= winner;
                  guard_cnt  <= GUARD_LOAD;
                  state      <= GUARD;
                  busy_r     <= 1'b1;
               end
            end
            GUARD: begin
               // Winner withdrew or arbitration disabled: abandon quietly.
               if (!owner_req || !enable) begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
               end else if (guard_cnt == 4'd0) begin
                  state    <= OWN;
                  grant_r  <= sel_onehot;
                  oe_r     <= 1'b1;
                  hold_cnt <= 8'd0;
               end else begin
                  guard_cnt <= guard_cnt - 4'd1;
               end
            end
            OWN: begin
               if (!owner_req || !enable || preempt) begin
                  state     <= DRAIN;
                  grant_r   <= 4'd0;
                  oe_r      <= 1'b0;
                  guard_cnt <= GUARD_LOAD;
               end else if (hold_cnt != HOLD_LAST) begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            DRAIN: begin
               // Inputs are ignored; the exit always passes through IDLE.
               if (guard_cnt == 4'd0) begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
               end else begin
                  guard_cnt <= guard_cnt - 4'd1;
               end
            end
            default: begin
               state   <= IDLE;
               grant_r <= 4'd0;
               oe_r    <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign configuration = {2'b00, sel};
   assign grant         = grant_r;
   assign oe_gate       = oe_r;
   assign busy          = busy_r;

endmodule

// File: tb/tb_top_line_owner_arb.sv
// Testbench for top_line_owner_arb with GUARD_CYC=2, MAX_HOLD=8.
// Outputs are compared as one packed word {configuration, grant, oe_gate, busy}.
module tb_top_line_owner_arb;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic [3:0] req;
   logic [3:0] configuration;
   logic [3:0] grant;
   logic       oe_gate;
   logic       busy;

   int checks;
   int errors;

   top_line_owner_arb #(.GUARD_CYC(2), .MAX_HOLD(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .req          (req),
      .configuration(configuration),
      .grant        (grant),
      .oe_gate      (oe_gate),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic [3:0] rq;
      logic [3:0] cfg;
      logic [3:0] gnt;
      logic       oe;
      logic       bsy;
   } vec_t;

   vec_t vecs[24];

   task automatic check(input string name, input logic [3:0] e_cfg, input logic [3:0] e_gnt,
                        input logic e_oe, input logic e_bsy);
      logic [9:0] act;
      logic [9:0] exp;
      act = {configuration, grant, oe_gate, busy};
      exp = {e_cfg, e_gnt, e_oe, e_bsy};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got cfg=%h grant=%b oe=%b busy=%b, expected cfg=%h grant=%b oe=%b busy=%b",
                  name, configuration, grant, oe_gate, busy, e_cfg, e_gnt, e_oe, e_bsy);
      end
   endtask

   task automatic step(input logic en_i, input logic [3:0] rq_i);
      enable = en_i;
      req    = rq_i;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic en_i, input logic [3:0] rq_i);
      rst_n  = 1'b0;
      enable = en_i;
      req    = rq_i;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      enable = 1'b0;
      req    = 4'd0;

      //            en    req      cfg    grant    oe    busy
      vecs[0]  = '{1'b1, 4'b0100, 4'd2, 4'b0000, 1'b0, 1'b1}; // win 2, GUARD
      vecs[1]  = '{1'b1, 4'b0100, 4'd2, 4'b0000, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 4'b0100, 4'd2, 4'b0100, 1'b1, 1'b1}; // grant after edge 2
      vecs[3]  = '{1'b1, 4'b0100, 4'd2, 4'b0100, 1'b1, 1'b1};
      vecs[4]  = '{1'b1, 4'b0000, 4'd2, 4'b0000, 1'b0, 1'b1}; // DRAIN
      vecs[5]  = '{1'b1, 4'b0000, 4'd2, 4'b0000, 1'b0, 1'b1};
      vecs[6]  = '{1'b1, 4'b0000, 4'd2, 4'b0000, 1'b0, 1'b0}; // IDLE
      vecs[7]  = '{1'b1, 4'b0010, 4'd1, 4'b0000, 1'b0, 1'b1}; // win 1
      vecs[8]  = '{1'b1, 4'b0010, 4'd1, 4'b0000, 1'b0, 1'b1};
      vecs[9]  = '{1'b1, 4'b0010, 4'd1, 4'b0010, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 4'b0010, 4'd1, 4'b0010, 1'b1, 1'b1};
      vecs[11] = '{1'b1, 4'b0000, 4'd1, 4'b0000, 1'b0, 1'b1}; // owner 1 drops
      vecs[12] = '{1'b1, 4'b0010, 4'd1, 4'b0000, 1'b0, 1'b1}; // req ignored in DRAIN
      vecs[13] = '{1'b1, 4'b0010, 4'd1, 4'b0000, 1'b0, 1'b0}; // IDLE at m+2
      vecs[14] = '{1'b1, 4'b0000, 4'd1, 4'b0000, 1'b0, 1'b0};
      vecs[15] = '{1'b1, 4'b1000, 4'd3, 4'b0000, 1'b0, 1'b1}; // win 3
      vecs[16] = '{1'b1, 4'b0000, 4'd3, 4'b0000, 1'b0, 1'b0}; // drop in GUARD
      vecs[17] = '{1'b0, 4'b1111, 4'd3, 4'b0000, 1'b0, 1'b0}; // disabled
      vecs[18] = '{1'b1, 4'b0110, 4'd1, 4'b0000, 1'b0, 1'b1}; // after 3: pick 1
      vecs[19] = '{1'b1, 4'b0000, 4'd1, 4'b0000, 1'b0, 1'b0};
      vecs[20] = '{1'b1, 4'b0011, 4'd0, 4'b0000, 1'b0, 1'b1}; // after 1: wrap to 0
      vecs[21] = '{1'b1, 4'b0000, 4'd0, 4'b0000, 1'b0, 1'b0};
      vecs[22] = '{1'b1, 4'b0100, 4'd2, 4'b0000, 1'b0, 1'b1}; // after 0: pick 2
      vecs[23] = '{1'b0, 4'b0100, 4'd2, 4'b0000, 1'b0, 1'b0}; // enable low in GUARD

      #2;
      check("reset_state", 4'd0, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 24; v++) begin
         step(vecs[v].en, vecs[v].rq);
         $display("vec %0d en=%b req=%b -> cfg=%0d grant=%b oe=%b busy=%b",
                  v, vecs[v].en, vecs[v].rq, configuration, grant, oe_gate, busy);
         check($sformatf("vec%0d", v), vecs[v].cfg, vecs[v].gnt, vecs[v].oe, vecs[v].bsy);
      end

      // Full contention from reset: 13-cycle period per owner
      // (2 GUARD, 8 OWN, 2 DRAIN, 1 IDLE), owners 0,1,2,3,0.
      do_reset(1'b1, 4'b1111);
      for (int e = 0; e < 65; e++) begin
         int         p;
         logic [1:0] n;
         logic [3:0] eg;
         @(posedge clk);
         #1;
         p  = e % 13;
         n  = 2'((e / 13) % 4);
         eg = (p >= 2 && p <= 9) ? (4'b0001 << n) : 4'b0000;
         check($sformatf("rotate_e%0d", e), {2'b00, n}, eg, eg != 4'd0, p != 12);
      end

      // Enable dropped while macro 2 owns under full contention.
      do_reset(1'b1, 4'b1111);
      for (int e = 0; e < 30; e++) begin
         @(posedge clk);
         #1;
      end
      check("own2_before_disable", 4'd2, 4'b0100, 1'b1, 1'b1);
      step(1'b0, 4'b1111);
      check("disable_drain", 4'd2, 4'b0000, 1'b0, 1'b1);
      step(1'b0, 4'b1111);
      step(1'b0, 4'b1111);
      check("disable_idle", 4'd2, 4'b0000, 1'b0, 1'b0);
      step(1'b0, 4'b1111);
      step(1'b0, 4'b1111);
      check("disable_no_grant", 4'd2, 4'b0000, 1'b0, 1'b0);
      step(1'b1, 4'b1111);
      check("reenable_pick3", 4'd3, 4'b0000, 1'b0, 1'b1);
      step(1'b1, 4'b1111);
      step(1'b1, 4'b1111);
      check("reenable_own3", 4'd3, 4'b1000, 1'b1, 1'b1);

      // Asynchronous reset between edges while macro 3 owns.
      rst_n = 1'b0;
      #1;
      check("async_reset", 4'd0, 4'b0000, 1'b0, 1'b0);
      enable = 1'b1;
      req    = 4'b1010;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 4'b1010);
      check("post_reset_pick1", 4'd1, 4'b0000, 1'b0, 1'b1);
      step(1'b1, 4'b1010);
      step(1'b1, 4'b1010);
      check("post_reset_own1", 4'd1, 4'b0010, 1'b1, 1'b1);

      // Sole requester keeps ownership past MAX_HOLD.
      for (int e = 0; e < 20; e++) begin
         step(1'b1, 4'b0010);
         check($sformatf("sole_hold_%0d", e), 4'd1, 4'b0010, 1'b1, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/top_line_owner_arb.md
TOP_LINE_OWNER_ARB -- requirements
Module: top_line_owner_arb

Interface
REQ-001 Parameter GUARD_CYC, default 2, range 1..15: dead cycles with oe_gate low around every ownership change.
REQ-002 Parameter MAX_HOLD, default 64, range 2..255: OWN cycles before a contended owner is preempted.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port enable, input, 1: arbitration enable; low drains and blocks new grants.
REQ-006 Port req, input, 4: level request per macro 0..3 for the shared pad line.
REQ-007 Port configuration, output, 4: mux select to the pad-line mux; value 0..3, bits [3:2] always 0.
REQ-008 Port grant, output, 4: one-hot grant to the current owner; all-zero when no owner.
REQ-009 Port oe_gate, output, 1: high only when pad-line drivers may be enabled.
REQ-010 Port busy, output, 1: high whenever state is not IDLE.

Function
REQ-011 FSM states: IDLE, GUARD, OWN, DRAIN; all outputs registered.
REQ-012 IDLE: grant=0, oe_gate=0, configuration holds last value.
REQ-013 IDLE, enable=1, req!=0 at an edge: round-robin winner = first set req bit searching from last_owner+1 mod 4 upward; on that edge configuration=winner, last_owner=winner, guard counter=GUARD_CYC-1, state=GUARD.
REQ-014 IDLE with enable=0 or req=0: remain IDLE.
REQ-015 GUARD: grant=0, oe_gate=0; counter decrements each edge; edge with counter==0 -> OWN, grant=onehot(configuration), oe_gate=1, hold counter=0.
REQ-016 Latency: winner sampled at edge k -> configuration valid after edge k, grant/oe_gate high after edge k+GUARD_CYC.
REQ-017 GUARD, winner's req low or enable low at an edge: -> IDLE on that edge, no grant issued.
REQ-018 OWN: hold counter increments per edge, saturates at MAX_HOLD-1.
REQ-019 OWN exits to DRAIN at an edge if: owner req low, or enable low, or (hold counter==MAX_HOLD-1 and any other req bit high); on that edge grant=0, oe_gate=0, counter=GUARD_CYC-1.
REQ-020 Simultaneous exit conditions: single DRAIN entry, identical behaviour.
REQ-021 OWN with no other requester at saturation: ownership retained indefinitely.
REQ-022 DRAIN: grant=0, oe_gate=0, configuration unchanged; edge with counter==0 -> IDLE; req/enable ignored during DRAIN.
REQ-023 configuration changes only on IDLE->GUARD transition; never while oe_gate=1 or within GUARD_CYC cycles after oe_gate falls.
REQ-024 Minimum one IDLE cycle between DRAIN and next GUARD.
REQ-025 grant and oe_gate always equal (oe_gate==|grant); at most one grant bit set.

Reset
REQ-026 rst_n low asynchronously forces: state=IDLE, configuration=0, grant=0, oe_gate=0, busy=0, last_owner=3, guard and hold counters=0.
REQ-027 Reset mid-OWN/GUARD/DRAIN: outputs drop immediately without waiting for clk; first arbitration after release gives priority to req[0].
REQ-028 rst_n deassertion requires no synchronizer inside the block; release is synchronous to clk at the top level.

Verification (GUARD_CYC=2, MAX_HOLD=8)
REQ-029 Single req=4'b0100 sampled at edge 0 -> configuration=2 after edge 0; grant=4'b0100, oe_gate=1 after edge 2; busy=1 from edge 0.
REQ-030 req=4'b1111 held from reset -> owners in order 0,1,2,3,0; each OWN lasts 8 cycles; oe_gate low 3 cycles (2 DRAIN+1 IDLE) then 2 GUARD cycles between owners.
REQ-031 Owner 1 drops req at edge m -> grant=0/oe_gate=0 after edge m, IDLE after edge m+2, configuration stays 1.
REQ-032 Winner 3 drops req during GUARD -> IDLE on next edge, grant never nonzero, configuration=3.
REQ-033 enable low during OWN of macro 2 with req=4'b1111 -> DRAIN then IDLE; no new grant until enable high; then owner 3 selected.
REQ-034 rst_n low between edges during OWN -> configuration=0, grant=0, oe_gate=0 asynchronously; after release req=4'b1010 grants macro 1 first.
